// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced 3-button stopwatch with BCD count, lap freeze and 4-digit scan
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 100000000,
  parameter int SCAN_DIV   = 100000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        btn_lap,
  output logic [3:0]  seg_an,
  output logic [3:0]  digit,
  output logic [15:0] count_bcd,
  output logic        running,
  output logic        wrap
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
  state_t state, nxt;
  logic [2:0] raw, s1, s2, lvl, press;
  logic [CW-1:0] dcnt [3];
  logic [TW-1:0] tdiv;
  logic [SW-1:0] sdiv;
  logic [1:0] sel, sel_nxt;
  logic [15:0] lap_reg, disp, cnt_inc;
  logic clr, start, lap, tick, swrap;
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic c;
    bcd_inc = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++)
      if (c) begin
        if (v[4*i +: 4] == 4'd9) bcd_inc[4*i +: 4] = 4'd0;
        else begin
          bcd_inc[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
  endfunction
  assign raw = {btn_lap, btn_clear, btn_start};
  assign {lap, clr, start} = press;
  // press is registered after acceptance, giving DEB_CYCLES+3 from raw edge to state change
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      lvl <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      press <= '0;
      for (int i = 0; i < 3; i++)
        if (s2[i] == lvl[i]) dcnt[i] <= '0;
        else if (dcnt[i] == CW'(DEB_CYCLES - 1)) begin
          dcnt[i] <= '0;
          lvl[i] <= s2[i];
          press[i] <= s2[i];
        end else dcnt[i] <= dcnt[i] + 1'b1;
    end
  end
  assign running = (state == RUN) || (state == LAP);
  assign tick = running && (tdiv == TW'(TICK_DIV - 1));
  assign cnt_inc = bcd_inc(count_bcd);
  always_comb begin
    nxt = state;
    if (clr) nxt = IDLE;
    else if (start) nxt = running ? PAUSE : RUN;
    else if (lap) nxt = (state == RUN) ? LAP : (state == LAP) ? RUN : state;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= IDLE;
      tdiv <= '0;
      count_bcd <= '0;
      lap_reg <= '0;
      wrap <= 1'b0;
    end else begin
      state <= nxt;
      if (running) tdiv <= tick ? '0 : tdiv + 1'b1;
      if (tick) count_bcd <= cnt_inc;
      if (state != LAP && nxt == LAP) lap_reg <= count_bcd;
      wrap <= tick && (count_bcd == 16'h9999);
    end
  end
  assign disp = (state == LAP) ? lap_reg : count_bcd;
  assign swrap = sdiv == SW'(SCAN_DIV - 1);
  assign sel_nxt = sel + {1'b0, swrap};
  always_ff @(posedge clk) begin
    if (rst) begin
      sdiv <= '0;
      sel <= '0;
      seg_an <= 4'b1110;
      digit <= '0;
    end else begin
      sdiv <= swrap ? '0 : sdiv + 1'b1;
      sel <= sel_nxt;
      seg_an <= ~(4'b0001 << sel_nxt);
      digit <= disp[{sel_nxt, 2'b00} +: 4];
    end
  end
endmodule
